// File: rtl/rainbow_scroller.sv
// rainbow_scroller: scrolling diagonal rainbow bands via a colour ROM, 4-clock pixel pipeline.
// Define RAINBOW_BOUNCE_EN to make the phase ping-pong 0->31->0 instead of wrapping.
module rainbow_scroller #(
    parameter int BAND_SHIFT      = 4,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        freeze,
    output logic [6:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        rgb_valid
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_t;
    state_t state, state_nx;
    logic [7:0] frame_cnt;
    logic [4:0] phase, phase_step, band;
    logic       start, step;
    logic [3:0] vo_d;
    logic [2:0] act_d;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (enable && frame_tick) ? RUN : IDLE;
            RUN:     state_nx = !enable ? IDLE : freeze ? FREEZE : RUN;
            FREEZE:  state_nx = !enable ? IDLE : freeze ? FREEZE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    assign start = (state == IDLE) && enable && frame_tick;
    assign step  = (state == RUN) && frame_tick && (frame_cnt == 8'(FRAMES_PER_STEP - 1));
    assign band  = 5'(x >> BAND_SHIFT) + 5'(y >> BAND_SHIFT) + phase;

`ifdef RAINBOW_BOUNCE_EN
    logic dir_up;
    assign phase_step = dir_up ? phase + 5'd1 : phase - 5'd1;
    // direction flips on the step that lands on an end value, so ends appear once
    always_ff @(posedge clk) begin
        if (reset || start)
            dir_up <= 1'b1;
        else if (step && (phase_step == 5'd31 || phase_step == 5'd0))
            dir_up <= ~dir_up;
    end
`else
    assign phase_step = phase + 5'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            frame_cnt <= '0;
            rom_addr  <= 7'd24;
            vo_d      <= '0;
            act_d     <= '0;
            rgb       <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                phase     <= '0;
                frame_cnt <= '0;
            end else if (state == RUN && frame_tick) begin
                frame_cnt <= step ? 8'd0 : frame_cnt + 8'd1;
                phase     <= step ? phase_step : phase;
            end
            rom_addr <= (state == IDLE) ? 7'd24 : 7'd24 + {2'b00, band};
            vo_d     <= {vo_d[2:0], video_on};
            act_d    <= {act_d[1:0], state != IDLE};
            // stage 2 of the delay lines lines up with rom_data for the same pixel
            rgb      <= (vo_d[2] && act_d[2]) ? rom_data : 12'h000;
        end
    end

    assign rgb_valid = vo_d[3];
endmodule

// File: tb/tb_rainbow_scroller.sv
// tb_rainbow_scroller: directed checks of the rainbow scroller with a 2-clock ROM model.
module tb_rainbow_scroller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        video_on = 1'b0, frame_tick = 1'b0, enable = 1'b0, freeze = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0, rom_q1 = '0;
    logic [11:0] rgb;
    logic        rgb_valid;
    int          nchecks = 0, nerrors = 0;
    logic [6:0]  exp_wrap;

    rainbow_scroller dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .enable(enable), .freeze(freeze),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [6:0] a);
        return {5'b10101, a};
    endfunction

    always @(posedge clk) begin
        rom_q1   <= rom_f(rom_addr);
        rom_data <= rom_q1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        nchecks++;
        if (rom_addr !== 7'd24) begin nerrors++; $display("FAIL reset_addr got %0d want 24", rom_addr); end
        nchecks++;
        if (rgb !== 12'h000 || rgb_valid !== 1'b0) begin nerrors++; $display("FAIL reset_out got rgb=%h valid=%b want 000/0", rgb, rgb_valid); end
        reset = 1'b0;
    endtask

    task automatic test_idle_no_tick();
        enable = 1'b1;
        video_on = 1'b1;
        x = 10'd100;
        repeat (100) tick();
        nchecks++;
        if (rom_addr !== 7'd24) begin nerrors++; $display("FAIL idle_addr got %0d want 24", rom_addr); end
        nchecks++;
        if (rgb !== 12'h000) begin nerrors++; $display("FAIL idle_rgb got %h want 000", rgb); end
        nchecks++;
        if (rgb_valid !== 1'b1) begin nerrors++; $display("FAIL idle_valid got %b want 1", rgb_valid); end
    endtask

    task automatic test_phase_step();
        x = '0;
        y = '0;
        pulse();
        repeat (8) pulse();
        nchecks++;
        if (rom_addr !== 7'd26) begin nerrors++; $display("FAIL step_addr got %0d want 26", rom_addr); end
        repeat (4) tick();
        nchecks++;
        if (rgb !== rom_f(7'd26)) begin nerrors++; $display("FAIL step_rgb got %h want %h", rgb, rom_f(7'd26)); end
    endtask

    task automatic test_stream();
        logic [6:0] ea;
        int bad_a = 0, bad_c = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse();
        y = '0;
        for (int j = 0; j < 1027; j++) begin
            if (j < 1024) x = 10'(j);
            tick();
            if (j < 1024) begin
                ea = 7'd24 + 7'((j >> 4) & 31);
                nchecks++;
                if (rom_addr !== ea) begin
                    nerrors++;
                    if (bad_a++ < 5) $display("FAIL stream_addr x=%0d got %0d want %0d", j, rom_addr, ea);
                end
            end
            if (j >= 3) begin
                ea = 7'd24 + 7'(((j - 3) >> 4) & 31);
                nchecks++;
                if (rgb !== rom_f(ea) || rgb_valid !== 1'b1) begin
                    nerrors++;
                    if (bad_c++ < 5) $display("FAIL stream_rgb x=%0d got %h/%b want %h/1", j - 3, rgb, rgb_valid, rom_f(ea));
                end
            end
        end
    endtask

    task automatic test_wrap();
        x = '0;
        y = '0;
        repeat (124) pulse();
        nchecks++;
        if (rom_addr !== 7'd55) begin nerrors++; $display("FAIL wrap_at31 got %0d want 55", rom_addr); end
        repeat (4) pulse();
`ifdef RAINBOW_BOUNCE_EN
        exp_wrap = 7'd54;
`else
        exp_wrap = 7'd24;
`endif
        nchecks++;
        if (rom_addr !== exp_wrap) begin nerrors++; $display("FAIL wrap_next got %0d want %0d", rom_addr, exp_wrap); end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        tick();
        repeat (20) pulse();
        nchecks++;
        if (rom_addr !== exp_wrap) begin nerrors++; $display("FAIL freeze_hold got %0d want %0d", rom_addr, exp_wrap); end
        nchecks++;
        if (rgb !== rom_f(exp_wrap)) begin nerrors++; $display("FAIL freeze_rgb got %h want %h", rgb, rom_f(exp_wrap)); end
        enable = 1'b0;
        tick();
        tick();
        nchecks++;
        if (rom_addr !== 7'd24) begin nerrors++; $display("FAIL disable_addr got %0d want 24", rom_addr); end
        tick();
        tick();
        nchecks++;
        if (rgb !== rom_f(exp_wrap)) begin nerrors++; $display("FAIL inflight_rgb got %h want %h", rgb, rom_f(exp_wrap)); end
        tick();
        nchecks++;
        if (rgb !== 12'h000 || rgb_valid !== 1'b1) begin nerrors++; $display("FAIL disable_rgb got %h/%b want 000/1", rgb, rgb_valid); end
        freeze = 1'b0;
    endtask

    task automatic test_reset_in_run();
        enable = 1'b1;
        pulse();
        repeat (4) pulse();
        nchecks++;
        if (rom_addr !== 7'd25) begin nerrors++; $display("FAIL run_addr got %0d want 25", rom_addr); end
        reset = 1'b1;
        tick();
        nchecks++;
        if (rgb !== 12'h000 || rgb_valid !== 1'b0 || rom_addr !== 7'd24) begin
            nerrors++;
            $display("FAIL midrun_reset got rgb=%h valid=%b addr=%0d want 000/0/24", rgb, rgb_valid, rom_addr);
        end
        reset = 1'b0;
        repeat (5) tick();
        nchecks++;
        if (rom_addr !== 7'd24 || rgb !== 12'h000 || rgb_valid !== 1'b1) begin
            nerrors++;
            $display("FAIL post_reset_idle got addr=%0d rgb=%h valid=%b want 24/000/1", rom_addr, rgb, rgb_valid);
        end
        pulse();
        nchecks++;
        if (rom_addr !== 7'd24) begin nerrors++; $display("FAIL reentry_phase got %0d want 24", rom_addr); end
        repeat (4) tick();
        nchecks++;
        if (rgb !== rom_f(7'd24)) begin nerrors++; $display("FAIL reentry_rgb got %h want %h", rgb, rom_f(7'd24)); end
    endtask

    initial begin
        test_reset();
        test_idle_no_tick();
        test_phase_step();
        test_stream();
        test_wrap();
        test_freeze();
        test_reset_in_run();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
